// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side memory for the cpu data port.
// Word RAM plus UART TX FIFO/serializer, LED register and cycle counter.
module data_mem_mmio #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int RAM_WORDS    = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  mem_read_address,
  input  logic [7:0]  mem_write_address,
  input  logic [31:0] mem_write_data,
  input  logic        mem_write_enable,
  output logic [31:0] mem_read_data,
  output logic        uart_tx,
  output logic [7:0]  led
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DEPTH   = 4'(FIFO_DEPTH);
  localparam logic [3:0] PTR_MAX = 4'(FIFO_DEPTH - 1);
  localparam logic [5:0] RAM_TOP = 6'(RAM_WORDS);
  localparam logic [5:0] W_TXDATA = 6'd60;
  localparam logic [5:0] W_STATUS = 6'd61;
  localparam logic [5:0] W_LED    = 6'd62;
  localparam logic [5:0] W_CYCLES = 6'd63;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  logic [5:0] rd_word, wr_word;
  logic       we_ram, we_tx, we_stat, we_led;
  logic       unused_addr_lsbs;

  assign rd_word = mem_read_address[7:2];
  assign wr_word = mem_write_address[7:2];
  assign unused_addr_lsbs = ^{mem_read_address[1:0],
                              mem_write_address[1:0]};

  assign we_ram  = mem_write_enable && (wr_word < RAM_TOP);
  assign we_tx   = mem_write_enable && (wr_word == W_TXDATA);
  assign we_stat = mem_write_enable && (wr_word == W_STATUS);
  assign we_led  = mem_write_enable && (wr_word == W_LED);

  state_e        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [3:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]    wr_ptr_q, wr_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    led_q, led_d;
  logic [31:0]   cyc_q, cyc_d;

  logic pop, push_ok, busy, full, empty;

  assign busy    = (state_q != IDLE);
  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == 4'd0);
  assign pop     = (state_q == IDLE) && !empty;
  // A full FIFO still takes a byte when the serializer drains one this edge.
  assign push_ok = we_tx && (!full || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop)
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? 4'd0 : rd_ptr_q + 4'd1;
    if (push_ok)
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? 4'd0 : wr_ptr_q + 4'd1;
    if (push_ok && !pop)
      count_d = count_q + 4'd1;
    else if (pop && !push_ok)
      count_d = count_q - 4'd1;
    if (we_stat && mem_write_data[7])
      ovf_d = 1'b0;
    if (we_tx && !push_ok)
      ovf_d = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d   = fifo_mem[rd_ptr_q];
          clk_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_MAX) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == CNT_MAX) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d = we_led ? mem_write_data[7:0] : led_q;
    cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      rd_ptr_q  <= 4'd0;
      wr_ptr_q  <= 4'd0;
      count_q   <= 4'd0;
      ovf_q     <= 1'b0;
      led_q     <= 8'd0;
      cyc_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      led_q     <= led_d;
      cyc_q     <= cyc_d;
    end
  end

  // Storage arrays carry no reset; RAM contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we_ram)
      ram[wr_word] <= mem_write_data;
    if (push_ok && rst_n)
      fifo_mem[wr_ptr_q] <= mem_write_data[7:0];
  end

  always_comb begin
    mem_read_data = '0;
    unique case (1'b1)
      (rd_word < RAM_TOP):    mem_read_data = ram[rd_word];
      (rd_word == W_STATUS):  mem_read_data = {24'd0, ovf_q, busy,
                                               full, empty, count_q};
      (rd_word == W_LED):     mem_read_data = {24'd0, led_q};
      (rd_word == W_CYCLES):  mem_read_data = cyc_q;
      default:                mem_read_data = '0;
    endcase
  end

  assign uart_tx = tx_q;
  assign led     = led_q;
endmodule
